// File: rtl/cache_pkg.sv
// Shared cache geometry, refill FSM state encoding and address-slicing helpers
// for the direct-mapped 64-line x 8-word cache.
package cache_pkg;

  localparam int INDEX_W    = 6;
  localparam int WORD_W     = 3;
  localparam int TAG_W      = 21;
  localparam int LINE_WORDS = 8;
  localparam int STATE_W    = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_WB_REQ  = 3'd1,
    ST_WB_WAIT = 3'd2,
    ST_FILL    = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_TAG     = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  typedef struct packed {
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] index;
    logic [WORD_W-1:0]  word;
    logic [1:0]         byte_off;
  } addr_fields_t;

  function automatic addr_fields_t split_addr(input logic [31:0] addr);
    addr_fields_t f;
    f.tag      = addr[31:11];
    f.index    = addr[10:5];
    f.word     = addr[4:2];
    f.byte_off = addr[1:0];
    return f;
  endfunction

  function automatic logic [31:0] line_base(input logic [TAG_W-1:0] tag,
                                            input logic [INDEX_W-1:0] index);
    return {tag, index, 5'b00000};
  endfunction

endpackage

// File: rtl/rd_lat_pipe.sv
// Tracks in-flight memory reads: a DEPTH-stage shift register of {valid, word}
// whose last stage lines up with the returning read data.
module rd_lat_pipe
  import cache_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              push_valid,
  input  logic [WORD_W-1:0] push_word,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_word
);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [WORD_W-1:0] word_q [DEPTH];
  logic [WORD_W-1:0] word_d [DEPTH];

  // Shift every stage by one; a word is only recorded alongside its valid bit.
  always_comb begin
    valid_d    = valid_q;
    word_d     = word_q;
    valid_d[0] = push_valid;
    if (push_valid) begin
      word_d[0] = push_word;
    end else begin
      word_d[0] = 3'd0;
    end
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      word_d[i]  = word_q[i-1];
    end
  end

  // Stage registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        word_q[i] <= 3'd0;
      end
    end else begin
      valid_q <= valid_d;
      word_q  <= word_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_word  = word_q[DEPTH-1];

endmodule

// File: rtl/line_refill_ctrl.sv
// Cache miss sequencer: optional victim write-back, 8-word burst refill from
// main memory into the data RAM, then tag update and a done pulse.
module line_refill_ctrl
  import cache_pkg::*;
#(
  parameter int MEM_RD_LAT = 1,
  parameter int MEM_AW     = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                miss_req,
  input  logic [31:0]         miss_addr,
  input  logic                victim_dirty,
  input  logic [TAG_W-1:0]    victim_tag,
  output logic                busy,
  output logic                done,
  output logic                wb_start,
  output logic [31:0]         wb_addr,
  input  logic                wb_done,
  output logic [MEM_AW-1:0]   mem_rd_addr,
  input  logic [31:0]         mem_rd_data,
  output logic                cache_we,
  output logic [8:0]          cache_waddr,
  output logic [31:0]         cache_wdata,
  output logic                tag_we,
  output logic [INDEX_W-1:0]  tag_waddr,
  output logic [22:0]         tag_wdata
);

  state_e               state_q, state_d;
  logic [WORD_W-1:0]    cnt_q, cnt_d;
  logic [INDEX_W-1:0]   index_q, index_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic [TAG_W-1:0]     vtag_q, vtag_d;
  logic [MEM_AW-4:0]    mline_q, mline_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 wb_start_q, wb_start_d;
  logic [31:0]          wb_addr_q, wb_addr_d;
  logic [MEM_AW-1:0]    mem_rd_addr_q, mem_rd_addr_d;
  logic                 tag_we_q, tag_we_d;
  logic [INDEX_W-1:0]   tag_waddr_q, tag_waddr_d;
  logic [22:0]          tag_wdata_q, tag_wdata_d;

  addr_fields_t         miss_f_s;
  logic                 unused_s;
  logic                 pipe_valid_s;
  logic [WORD_W-1:0]    pipe_word_s;

  assign miss_f_s = split_addr(miss_addr);
  assign unused_s = ^{miss_f_s.word, miss_f_s.byte_off};

  // Next-state logic; outputs are derived from the next state so they register in step.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    index_d = index_q;
    tag_d   = tag_q;
    vtag_d  = vtag_q;
    mline_d = mline_q;
    case (state_q)
      ST_IDLE: begin
        if (miss_req) begin
          index_d = miss_f_s.index;
          tag_d   = miss_f_s.tag;
          vtag_d  = victim_tag;
          mline_d = miss_addr[MEM_AW+1:5];
          cnt_d   = 3'd0;
          state_d = victim_dirty ? ST_WB_REQ : ST_FILL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WB_REQ:  state_d = ST_WB_WAIT;
      ST_WB_WAIT: begin
        if (wb_done) begin
          state_d = ST_FILL;
        end else begin
          state_d = ST_WB_WAIT;
        end
      end
      ST_FILL: begin
        if (cnt_q == 3'(LINE_WORDS - 1)) begin
          cnt_d   = 3'd0;
          state_d = ST_DRAIN;
        end else begin
          cnt_d   = cnt_q + 3'd1;
        end
      end
      // The counter is reused to time out the read latency of the last word.
      ST_DRAIN: begin
        if (cnt_q == 3'(MEM_RD_LAT - 1)) begin
          cnt_d   = 3'd0;
          state_d = ST_TAG;
        end else begin
          cnt_d   = cnt_q + 3'd1;
        end
      end
      ST_TAG:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase

    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
    wb_start_d = (state_d == ST_WB_REQ);
    if ((state_d == ST_WB_REQ) || (state_d == ST_WB_WAIT)) begin
      wb_addr_d = line_base(vtag_d, index_d);
    end else begin
      wb_addr_d = 32'd0;
    end
    if (state_d == ST_FILL) begin
      mem_rd_addr_d = {mline_d, cnt_d};
    end else begin
      mem_rd_addr_d = '0;
    end
    tag_we_d = (state_d == ST_TAG);
    if (tag_we_d) begin
      tag_waddr_d = index_d;
      tag_wdata_d = {1'b1, 1'b0, tag_d};
    end else begin
      tag_waddr_d = 6'd0;
      tag_wdata_d = 23'd0;
    end
  end

  // FSM state, latched miss context and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 3'd0;
      index_q       <= 6'd0;
      tag_q         <= 21'd0;
      vtag_q        <= 21'd0;
      mline_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      wb_start_q    <= 1'b0;
      wb_addr_q     <= 32'd0;
      mem_rd_addr_q <= '0;
      tag_we_q      <= 1'b0;
      tag_waddr_q   <= 6'd0;
      tag_wdata_q   <= 23'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      index_q       <= index_d;
      tag_q         <= tag_d;
      vtag_q        <= vtag_d;
      mline_q       <= mline_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      wb_start_q    <= wb_start_d;
      wb_addr_q     <= wb_addr_d;
      mem_rd_addr_q <= mem_rd_addr_d;
      tag_we_q      <= tag_we_d;
      tag_waddr_q   <= tag_waddr_d;
      tag_wdata_q   <= tag_wdata_d;
    end
  end

  rd_lat_pipe #(.DEPTH(MEM_RD_LAT)) u_rd_lat_pipe (
    .clk        (clk),
    .clr        (rst),
    .push_valid (state_q == ST_FILL),
    .push_word  (cnt_q),
    .out_valid  (pipe_valid_s),
    .out_word   (pipe_word_s)
  );

  assign busy        = busy_q;
  assign done        = done_q;
  assign wb_start    = wb_start_q;
  assign wb_addr     = wb_addr_q;
  assign mem_rd_addr = mem_rd_addr_q;
  assign tag_we      = tag_we_q;
  assign tag_waddr   = tag_waddr_q;
  assign tag_wdata   = tag_wdata_q;
  // Read data passes straight through; the pipe only supplies timing and word index.
  assign cache_we    = pipe_valid_s;
  assign cache_waddr = pipe_valid_s ? {index_q, pipe_word_s} : 9'd0;
  assign cache_wdata = pipe_valid_s ? mem_rd_data : 32'd0;

endmodule

// File: tb/tb_line_refill_ctrl.sv
// Bench for line_refill_ctrl: drives two instances (MEM_RD_LAT 1 and 3) with the
// same miss stream and checks outputs per cycle plus a cache-write scoreboard.
`timescale 1ns/1ps
module tb_line_refill_ctrl;

  typedef struct {
    logic [31:0] addr;
    logic        dirty;
    logic [20:0] vtag;
    int          wbd;
    bit          spurious;
    bit          toggle;
    int          done1;
    logic [31:0] exp_wb_addr;
    logic [22:0] exp_tag;
  } vec_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic [8:0]  waddr;
    logic [31:0] wdata;
  } wr_t;

  logic        clk, rst, miss_req, victim_dirty, wb_done, mon_en;
  logic [31:0] miss_addr;
  logic [20:0] victim_tag;
  logic        busy_a [2], done_a [2], wb_start_a [2], cache_we_a [2], tag_we_a [2];
  logic [31:0] wb_addr_a [2], cache_wdata_a [2], mem_rd_data_a [2];
  logic [9:0]  mem_rd_addr_a [2];
  logic [8:0]  cache_waddr_a [2];
  logic [5:0]  tag_waddr_a [2];
  logic [22:0] tag_wdata_a [2];

  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;
  wr_t q0[$], q1[$];
  vec_t vt [5];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mdata(input logic [9:0] a);
    return {6'h2A, a, 6'h15, a};
  endfunction

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s u%0d cyc=%0d: got %h, expected %h", nm, inst, cyc, act, exp);
    end
  endtask

  task automatic push_wr(input int i, input wr_t w);
    if (i == 0) q0.push_back(w); else q1.push_back(w);
  endtask

  function automatic wr_t pop_wr(input int i);
    if (i == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int L = (g == 0) ? 1 : 3;
    logic [9:0] hist [L];
    wr_t        w_s;

    always @(posedge clk) begin
      hist[0] <= mem_rd_addr_a[g];
      for (int i = 1; i < L; i++) hist[i] <= hist[i-1];
    end
    assign mem_rd_data_a[g] = mdata(hist[L-1]);

    line_refill_ctrl #(.MEM_RD_LAT(L), .MEM_AW(10)) dut (
      .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
      .victim_dirty(victim_dirty), .victim_tag(victim_tag),
      .busy(busy_a[g]), .done(done_a[g]), .wb_start(wb_start_a[g]),
      .wb_addr(wb_addr_a[g]), .wb_done(wb_done),
      .mem_rd_addr(mem_rd_addr_a[g]), .mem_rd_data(mem_rd_data_a[g]),
      .cache_we(cache_we_a[g]), .cache_waddr(cache_waddr_a[g]), .cache_wdata(cache_wdata_a[g]),
      .tag_we(tag_we_a[g]), .tag_waddr(tag_waddr_a[g]), .tag_wdata(tag_wdata_a[g])
    );

    always @(negedge clk) begin
      if (mon_en) begin
        if (cache_we_a[g]) begin
          if (qsize(g) == 0) begin
            chk("wr_unexpected", g, 32'(cache_we_a[g]), 32'h0);
          end else begin
            w_s = pop_wr(g);
            chk("wr_cycle", g, 32'(cyc), w_s.cyc);
            chk("wr_addr", g, 32'(cache_waddr_a[g]), 32'(w_s.waddr));
            chk("wr_data", g, cache_wdata_a[g], w_s.wdata);
          end
        end else begin
          chk("wr_idle", g, 32'(cache_waddr_a[g]) | cache_wdata_a[g], 32'h0);
        end
      end
    end
  end

  task automatic chk_idle(input string nm);
    for (int i = 0; i < 2; i++) begin
      chk({nm, "_ctrl"}, i, 32'({busy_a[i], done_a[i], wb_start_a[i], cache_we_a[i], tag_we_a[i]}), 32'h0);
      chk({nm, "_mem"}, i, 32'(mem_rd_addr_a[i]), 32'h0);
      chk({nm, "_wb"}, i, wb_addr_a[i], 32'h0);
      chk({nm, "_cache"}, i, 32'(cache_waddr_a[i]) | cache_wdata_a[i], 32'h0);
      chk({nm, "_tag"}, i, 32'({tag_waddr_a[i], tag_wdata_a[i]}), 32'h0);
    end
  endtask

  task automatic run_miss(input vec_t v);
    int  acc0, fs, dc, L;
    wr_t w;
    fs = v.done1 - 10;
    miss_req = 1'b1; miss_addr = v.addr; victim_dirty = v.dirty; victim_tag = v.vtag;
    acc0 = cyc;
    for (int i = 0; i < 2; i++) begin
      L = lat_of(i);
      for (int k = 0; k < 8; k++) begin
        w.cyc   = 32'(acc0 + fs + k + L);
        w.waddr = {v.addr[10:5], 3'(k)};
        w.wdata = mdata({v.addr[11:5], 3'(k)});
        push_wr(i, w);
      end
    end
    for (int c = 1; c <= v.done1 + 4; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        dc = fs + 9 + lat_of(i);
        chk("ctrl", i, 32'({busy_a[i], done_a[i], wb_start_a[i], tag_we_a[i]}),
            32'({c <= dc, c == dc, v.dirty && c == 1, c == dc - 1}));
        chk("wb_addr", i, wb_addr_a[i], (v.dirty && c < fs) ? v.exp_wb_addr : 32'h0);
        chk("mem_rd_addr", i, 32'(mem_rd_addr_a[i]),
            (c >= fs && c < fs + 8) ? 32'({v.addr[11:5], 3'(c - fs)}) : 32'h0);
        chk("tag", i, 32'({tag_waddr_a[i], tag_wdata_a[i]}),
            (c == dc - 1) ? 32'({v.addr[10:5], v.exp_tag}) : 32'h0);
      end
      miss_req = v.toggle ? (c <= 11 && (c % 2) == 1) : 1'b0;
      wb_done  = (v.dirty && c == fs - 1) || (v.spurious && c == fs + 3);
    end
    for (int i = 0; i < 2; i++) chk("wr_left", i, 32'(qsize(i)), 32'h0);
  endtask

  // Clean miss with reset asserted in the 4th FILL cycle.
  task automatic run_reset();
    int  acc0, L;
    wr_t w;
    miss_req = 1'b1; miss_addr = 32'h0000_1A40; victim_dirty = 1'b0; victim_tag = 21'h0;
    acc0 = cyc;
    for (int i = 0; i < 2; i++) begin
      L = lat_of(i);
      for (int k = 0; k < 8; k++) begin
        if (1 + k + L <= 4) begin
          w.cyc   = 32'(acc0 + 1 + k + L);
          w.waddr = {6'h12, 3'(k)};
          w.wdata = mdata({7'h52, 3'(k)});
          push_wr(i, w);
        end
      end
    end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c <= 4) begin
        for (int i = 0; i < 2; i++) begin
          chk("rst_fill_mem", i, 32'(mem_rd_addr_a[i]), 32'({7'h52, 3'(c - 1)}));
          chk("rst_fill_ctrl", i, 32'({busy_a[i], tag_we_a[i]}), 32'h2);
        end
      end else begin
        chk_idle("after_rst");
      end
      miss_req = 1'b0;
      rst = (c == 4);
    end
    for (int i = 0; i < 2; i++) chk("rst_wr_left", i, 32'(qsize(i)), 32'h0);
  endtask

  initial begin
    rst = 1'b1; miss_req = 1'b0; miss_addr = 32'h0; victim_dirty = 1'b0;
    victim_tag = 21'h0; wb_done = 1'b0; mon_en = 1'b0;
    vt[0] = '{32'h0000_1A40, 1'b0, 21'h000000, 0,  1'b0, 1'b0, 11, 32'h0000_0000, 23'h400003};
    vt[1] = '{32'h0000_1A40, 1'b1, 21'h1FFFFF, 10, 1'b0, 1'b0, 22, 32'hFFFF_FA40, 23'h400003};
    vt[2] = '{32'hFFFF_FFE4, 1'b0, 21'h000000, 0,  1'b1, 1'b1, 11, 32'h0000_0000, 23'h5FFFFF};
    vt[3] = '{32'h8000_0020, 1'b1, 21'h0AAAAA, 1,  1'b0, 1'b0, 13, 32'h5555_5020, 23'h500000};
    vt[4] = '{32'h0000_0000, 1'b0, 21'h000000, 0,  1'b0, 1'b0, 11, 32'h0000_0000, 23'h400000};
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk_idle("post_reset");
    for (int t = 0; t < 5; t++) run_miss(vt[t]);
    run_reset();
    run_miss(vt[0]);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
